// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types for the write and read masters.
// Response codes, write FSM states and sizing helpers.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } t_axi_resp;

   typedef enum logic [1:0] {
      IDLE,
      ADDR_DATA,
      RESP
   } t_wr_state;

   // Watchdog counter must be able to hold the limit itself.
   function automatic int cnt_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// Generic synchronous FIFO, show-ahead read, async active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         arstn,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop on the same edge frees the slot a full push needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi4_lite_master_write_q.sv
// Queued AXI4-Lite write master: concurrent AW/W, one outstanding
// transaction, sticky fault capture and a response watchdog.
module axi4_lite_master_write_q
   import axi4_lite_pkg::*;
#(
   parameter int          AXI_ADDR_WIDTH = 64,
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          QUEUE_DEPTH    = 4,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [2:0]  PROT_VALUE     = 3'b000
) (
   input  logic                          clk,
   input  logic                          arstn,
   input  logic                          i_req_valid,
   output logic                          o_req_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]     i_addr,
   input  logic [AXI_DATA_WIDTH-1:0]     i_data,
   input  logic [AXI_DATA_WIDTH/8-1:0]   i_strb,
   input  logic                          i_clear_fault,
   output logic                          o_done,
   output logic                          o_busy,
   output logic                          o_write_fault,
   output logic [AXI_ADDR_WIDTH-1:0]     o_fault_addr,
   output logic [1:0]                    o_fault_resp,
   output logic                          o_timeout,
   input  logic                          AW_READY,
   output logic                          AW_VALID,
   output logic [2:0]                    AW_PROT,
   output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
   input  logic                          W_READY,
   output logic                          W_VALID,
   output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
   output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
   input  logic [1:0]                    B_RESP,
   input  logic                          B_VALID,
   output logic                          B_READY
);

   localparam int SW  = AXI_DATA_WIDTH / 8;
   localparam int QCW = $clog2(QUEUE_DEPTH + 1);
   localparam int CW  = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_HIT = CW'(TIMEOUT_CYCLES - 1);

   typedef struct packed {
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [SW-1:0]             strb;
   } t_wr_req;

   t_wr_req            req_in;
   t_wr_req            head;
   logic               q_push;
   logic               q_pop;
   logic               q_full;
   logic               q_empty;
   logic [QCW-1:0]     q_count;

   t_wr_state                 state_q, state_d;
   logic                      aw_valid_q, aw_valid_d;
   logic                      w_valid_q, w_valid_d;
   logic                      b_ready_q, b_ready_d;
   logic                      done_q, done_d;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [SW-1:0]             w_strb_q, w_strb_d;
   logic                      fault_q, fault_d;
   logic [AXI_ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
   t_axi_resp                 fault_resp_q, fault_resp_d;
   logic                      timeout_q, timeout_d;
   logic [CW-1:0]             wd_cnt_q, wd_cnt_d;

   assign req_in = '{addr: i_addr, data: i_data, strb: i_strb};
   assign o_req_ready = ~q_full;
   assign q_push = i_req_valid & ~q_full;

   fifo_sync #(
      .WIDTH ($bits(t_wr_req)),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk   (clk),
      .arstn (arstn),
      .push  (q_push),
      .pop   (q_pop),
      .din   (req_in),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   always_comb begin
      state_d      = state_q;
      aw_valid_d   = aw_valid_q;
      w_valid_d    = w_valid_q;
      b_ready_d    = b_ready_q;
      done_d       = 1'b0;
      aw_addr_d    = aw_addr_q;
      w_data_d     = w_data_q;
      w_strb_d     = w_strb_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      fault_resp_d = fault_resp_q;
      timeout_d    = timeout_q;
      wd_cnt_d     = wd_cnt_q;
      q_pop        = 1'b0;

      if (i_clear_fault) begin
         fault_d   = 1'b0;
         timeout_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (!q_empty) begin
               q_pop      = 1'b1;
               aw_addr_d  = head.addr;
               w_data_d   = head.data;
               w_strb_d   = head.strb;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               wd_cnt_d   = '0;
               state_d    = ADDR_DATA;
            end
         end
         ADDR_DATA: begin
            if (AW_READY) begin
               aw_valid_d = 1'b0;
            end
            if (W_READY) begin
               w_valid_d = 1'b0;
            end
            if ((!aw_valid_q || AW_READY) &&
                (!w_valid_q || W_READY)) begin
               b_ready_d = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (B_VALID) begin
               b_ready_d = 1'b0;
               done_d    = 1'b1;
               state_d   = IDLE;
               // A fresh fault beats a clear landing on the same edge.
               if (B_RESP[1] && (!fault_q || i_clear_fault)) begin
                  fault_d      = 1'b1;
                  fault_addr_d = aw_addr_q;
                  fault_resp_d = t_axi_resp'(B_RESP);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Saturating at the limit makes the expiry a one-shot event.
      if (state_q != IDLE) begin
         if (wd_cnt_q != CNT_MAX) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
         end
         if (TIMEOUT_CYCLES != 0 && wd_cnt_q == CNT_HIT) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q      <= IDLE;
         aw_valid_q   <= 1'b0;
         w_valid_q    <= 1'b0;
         b_ready_q    <= 1'b0;
         done_q       <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         fault_resp_q <= OKAY;
         timeout_q    <= 1'b0;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         aw_valid_q   <= aw_valid_d;
         w_valid_q    <= w_valid_d;
         b_ready_q    <= b_ready_d;
         done_q       <= done_d;
         aw_addr_q    <= aw_addr_d;
         w_data_q     <= w_data_d;
         w_strb_q     <= w_strb_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         fault_resp_q <= fault_resp_d;
         timeout_q    <= timeout_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   assign AW_PROT       = PROT_VALUE;
   assign AW_VALID      = aw_valid_q;
   assign AW_ADDR       = aw_addr_q;
   assign W_VALID       = w_valid_q;
   assign W_DATA        = w_data_q;
   assign W_STRB        = w_strb_q;
   assign B_READY       = b_ready_q;
   assign o_done        = done_q;
   assign o_busy        = (q_count != '0) || (state_q != IDLE);
   assign o_write_fault = fault_q;
   assign o_fault_addr  = fault_addr_q;
   assign o_fault_resp  = fault_resp_q;
   assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_axi4_lite_master_write_q.sv
// Directed bench for axi4_lite_master_write_q with a write scoreboard.
// Slave model answers B_RESP from the last accepted AW address.
module tb_axi4_lite_master_write_q;
   import axi4_lite_pkg::*;

   localparam int AW = 64;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          arstn = 1'b0;
   logic          i_req_valid;
   logic          o_req_ready;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_data;
   logic [SW-1:0] i_strb;
   logic          i_clear_fault;
   logic          o_done;
   logic          o_busy;
   logic          o_write_fault;
   logic [AW-1:0] o_fault_addr;
   logic [1:0]    o_fault_resp;
   logic          o_timeout;
   logic          AW_READY;
   logic          AW_VALID;
   logic [2:0]    AW_PROT;
   logic [AW-1:0] AW_ADDR;
   logic          W_READY;
   logic          W_VALID;
   logic [DW-1:0] W_DATA;
   logic [SW-1:0] W_STRB;
   logic [1:0]    B_RESP;
   logic          B_VALID;
   logic          B_READY;

   int vectors = 0;
   int miscompares = 0;
   int done_seen = 0;
   int base;

   logic [AW-1:0]      exp_aw [$];
   logic [DW+SW-1:0]   exp_w  [$];
   logic [AW-1:0]      slave_addr = '0;

   always #5 clk = ~clk;

   axi4_lite_master_write_q #(
      .AXI_ADDR_WIDTH (AW),
      .AXI_DATA_WIDTH (DW),
      .QUEUE_DEPTH    (4),
      .TIMEOUT_CYCLES (8),
      .PROT_VALUE     (3'b101)
   ) dut (
      .clk           (clk),
      .arstn         (arstn),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_addr        (i_addr),
      .i_data        (i_data),
      .i_strb        (i_strb),
      .i_clear_fault (i_clear_fault),
      .o_done        (o_done),
      .o_busy        (o_busy),
      .o_write_fault (o_write_fault),
      .o_fault_addr  (o_fault_addr),
      .o_fault_resp  (o_fault_resp),
      .o_timeout     (o_timeout),
      .AW_READY      (AW_READY),
      .AW_VALID      (AW_VALID),
      .AW_PROT       (AW_PROT),
      .AW_ADDR       (AW_ADDR),
      .W_READY       (W_READY),
      .W_VALID       (W_VALID),
      .W_DATA        (W_DATA),
      .W_STRB        (W_STRB),
      .B_RESP        (B_RESP),
      .B_VALID       (B_VALID),
      .B_READY       (B_READY)
   );

   always @(posedge clk) begin
      if (AW_VALID && AW_READY) begin
         slave_addr <= AW_ADDR;
      end
   end

   assign B_RESP = (slave_addr == 64'h2008) ? SLVERR :
                   (slave_addr == 64'h200C) ? SLVERR :
                   (slave_addr == 64'h3000) ? DECERR : OKAY;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
      for (int i = 0; i < 50 && !o_req_ready; i++) tick;
      chk("req_ready_wait", o_req_ready, 1);
      i_req_valid = 1'b1;
      i_addr = a;
      i_data = d;
      i_strb = s;
      exp_aw.push_back(a);
      exp_w.push_back({d, s});
      tick;
      i_req_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (arstn) begin
         if (o_done) done_seen++;
         if (AW_VALID && AW_READY) begin
            chk("aw_expected", exp_aw.size() != 0, 1);
            if (exp_aw.size() != 0)
               chk("aw_addr", AW_ADDR, exp_aw.pop_front());
         end
         if (W_VALID && W_READY) begin
            chk("w_expected", exp_w.size() != 0, 1);
            if (exp_w.size() != 0)
               chk("w_data_strb", {W_DATA, W_STRB}, exp_w.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      i_req_valid = 1'b0;
      i_addr = '0;
      i_data = '0;
      i_strb = '0;
      i_clear_fault = 1'b0;
      AW_READY = 1'b1;
      W_READY = 1'b1;
      B_VALID = 1'b1;

      // reset state
      #12;
      chk("rst_aw_valid", AW_VALID, 0);
      chk("rst_w_valid", W_VALID, 0);
      chk("rst_b_ready", B_READY, 0);
      chk("rst_done", o_done, 0);
      chk("rst_fault", o_write_fault, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_aw_addr", AW_ADDR, 0);
      chk("rst_w_data", W_DATA, 0);
      chk("rst_w_strb", W_STRB, 0);
      chk("rst_fault_addr", o_fault_addr, 0);
      chk("rst_fault_resp", o_fault_resp, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_req_ready", o_req_ready, 1);
      chk("aw_prot", AW_PROT, 3'b101);
      @(posedge clk);
      #1 arstn = 1'b1;
      tick;

      // single write, zero-wait slave
      push_req(64'h1000, 32'hDEADBEEF, 4'b0011);
      chk("t1_c1_aw_valid", AW_VALID, 0);
      tick;
      chk("t1_c2_aw_valid", AW_VALID, 1);
      chk("t1_c2_w_valid", W_VALID, 1);
      chk("t1_c2_aw_addr", AW_ADDR, 64'h1000);
      chk("t1_c2_w_data", W_DATA, 32'hDEADBEEF);
      chk("t1_c2_w_strb", W_STRB, 4'b0011);
      tick;
      chk("t1_c3_b_ready", B_READY, 1);
      chk("t1_c3_aw_valid", AW_VALID, 0);
      chk("t1_c3_done", o_done, 0);
      tick;
      chk("t1_c4_done", o_done, 1);
      chk("t1_c4_b_ready", B_READY, 0);
      tick;
      chk("t1_c5_done", o_done, 0);
      chk("t1_c5_fault", o_write_fault, 0);
      chk("t1_c5_busy", o_busy, 0);

      // skewed handshakes
      AW_READY = 1'b0;
      W_READY = 1'b0;
      push_req(64'h1100, 32'h12345678, 4'b1111);
      tick;
      chk("t2_c2_aw_valid", AW_VALID, 1);
      chk("t2_c2_w_valid", W_VALID, 1);
      tick;
      W_READY = 1'b1;
      chk("t2_c3_w_valid", W_VALID, 1);
      tick;
      W_READY = 1'b0;
      chk("t2_c4_w_valid", W_VALID, 0);
      chk("t2_c4_aw_valid", AW_VALID, 1);
      chk("t2_c4_b_ready", B_READY, 0);
      tick;
      chk("t2_c5_aw_valid", AW_VALID, 1);
      chk("t2_c5_b_ready", B_READY, 0);
      tick;
      AW_READY = 1'b1;
      chk("t2_c6_b_ready", B_READY, 0);
      tick;
      chk("t2_c7_aw_valid", AW_VALID, 0);
      chk("t2_c7_b_ready", B_READY, 1);
      tick;
      chk("t2_c8_done", o_done, 1);
      W_READY = 1'b1;
      tick;

      // queue full with AW stalled
      AW_READY = 1'b0;
      base = done_seen;
      for (int k = 0; k < 5; k++)
         push_req(64'h5000 + 64'(k * 16), $urandom, 4'(k + 1));
      chk("t3_full_ready", o_req_ready, 0);
      chk("t3_full_busy", o_busy, 1);
      i_req_valid = 1'b1;
      i_addr = 64'hBAD0;
      tick;
      i_req_valid = 1'b0;
      chk("t3_still_full", o_req_ready, 0);
      AW_READY = 1'b1;
      for (int i = 0; i < 100 && done_seen < base + 5; i++) tick;
      chk("t3_done_count", done_seen, base + 5);
      repeat (6) tick;
      chk("t3_no_extra", done_seen, base + 5);
      chk("t3_idle_busy", o_busy, 0);
      chk("t3_sb_empty", exp_aw.size(), 0);

      // fault capture
      i_clear_fault = 1'b1;
      tick;
      i_clear_fault = 1'b0;
      base = done_seen;
      push_req(64'h2000, 32'hA0, 4'hF);
      push_req(64'h2004, 32'hA1, 4'hF);
      push_req(64'h2008, 32'hA2, 4'hF);
      push_req(64'h200C, 32'hA3, 4'hF);
      for (int i = 0; i < 100 && done_seen < base + 4; i++) tick;
      chk("t4_done_count", done_seen, base + 4);
      chk("t4_fault", o_write_fault, 1);
      chk("t4_fault_addr", o_fault_addr, 64'h2008);
      chk("t4_fault_resp", o_fault_resp, 2'b10);
      B_VALID = 1'b0;
      push_req(64'h3000, 32'hA4, 4'hF);
      for (int i = 0; i < 20 && !B_READY; i++) tick;
      chk("t4_wait_bready", B_READY, 1);
      B_VALID = 1'b1;
      i_clear_fault = 1'b1;
      tick;
      i_clear_fault = 1'b0;
      chk("t4_clr_fault", o_write_fault, 1);
      chk("t4_clr_addr", o_fault_addr, 64'h3000);
      chk("t4_clr_resp", o_fault_resp, 2'b11);
      chk("t4_clr_done", o_done, 1);
      i_clear_fault = 1'b1;
      tick;
      i_clear_fault = 1'b0;
      chk("t4_cleared", o_write_fault, 0);

      // watchdog
      B_VALID = 1'b0;
      chk("t5_pre_timeout", o_timeout, 0);
      push_req(64'h4000, 32'h55AA55AA, 4'b1010);
      repeat (8) tick;
      chk("t5_c9_timeout", o_timeout, 0);
      tick;
      chk("t5_c10_timeout", o_timeout, 1);
      chk("t5_c10_b_ready", B_READY, 1);
      B_VALID = 1'b1;
      tick;
      chk("t5_done", o_done, 1);
      chk("t5_timeout_held", o_timeout, 1);
      tick;
      chk("t5_timeout_sticky", o_timeout, 1);
      i_clear_fault = 1'b1;
      tick;
      i_clear_fault = 1'b0;
      chk("t5_timeout_clr", o_timeout, 0);

      // reset mid-RESP with two queued entries
      B_VALID = 1'b0;
      push_req(64'h6000, 32'hC0, 4'hF);
      push_req(64'h6010, 32'hC1, 4'hF);
      push_req(64'h6020, 32'hC2, 4'hF);
      tick;
      chk("t6_in_resp", B_READY, 1);
      chk("t6_busy", o_busy, 1);
      arstn = 1'b0;
      #1;
      chk("t6_aw_valid", AW_VALID, 0);
      chk("t6_w_valid", W_VALID, 0);
      chk("t6_b_ready", B_READY, 0);
      chk("t6_busy_rst", o_busy, 0);
      chk("t6_req_ready", o_req_ready, 1);
      chk("t6_aw_addr", AW_ADDR, 0);
      chk("t6_w_data", W_DATA, 0);
      chk("t6_fault_addr", o_fault_addr, 0);
      chk("t6_fault_resp", o_fault_resp, 0);
      exp_aw.delete();
      exp_w.delete();
      base = done_seen;
      B_VALID = 1'b1;
      @(posedge clk);
      #1 arstn = 1'b1;
      repeat (10) tick;
      chk("t6_no_done", done_seen, base);
      chk("t6_idle", o_busy, 0);
      chk("t6_aw_quiet", AW_VALID, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
